// File: rtl/mvu_seq_pkg.sv
// rtl/mvu_seq_pkg.sv - shared types for the MVU command sequencer
//
// Purpose: opcode, command and state types shared by the sequencer, its
// watchdog and the bench. The localparams give the default geometry that
// seq_cmd_t is laid out with.
package mvu_seq_pkg;

    localparam int SEQ_NMVU   = 8;
    localparam int SEQ_CH_W   = $clog2(SEQ_NMVU);
    localparam int SEQ_ADDR_W = 15;
    localparam int SEQ_WORD_W = 64;
    localparam int SEQ_TMO_W  = 20;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_WRW        = 3'd1,
        OP_CLR        = 3'd2,
        OP_START      = 3'd3,
        OP_WAIT       = 3'd4,
        OP_START_WAIT = 3'd5,
        OP_BWRW       = 3'd6,
        OP_ILLEGAL    = 3'd7
    } seq_op_t;

    typedef struct packed {
        seq_op_t                 op;
        logic [SEQ_CH_W-1:0]     ch;
        logic [SEQ_ADDR_W-1:0]   addr;
        logic [SEQ_WORD_W-1:0]   word;
    } seq_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } seq_state_t;

    function automatic logic seq_op_legal(input seq_op_t op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/mvu_cmd_sequencer_watchdog.sv
// rtl/mvu_cmd_sequencer_watchdog.sv - saturating WAIT watchdog for the MVU command sequencer
//
// Purpose: counts cycles spent waiting for a channel's done and flags expiry.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the counter back to 0 (has priority over run)
//   run        : count this cycle
//   limit      : expiry threshold in cycles, 0 disables expiry
//   expired    : counter has reached limit-1 while running
module mvu_seq_watchdog
    import mvu_seq_pkg::*;
#(
    parameter int TMO_W = SEQ_TMO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // The counter holds 0 in the first waiting cycle, so expiry at limit-1
    // means the wait lasted exactly 'limit' cycles. '>=' keeps a limit that
    // is lowered mid-wait from being skipped over.
    assign expired = run && (limit != '0) && (count >= (limit - 1'b1));

endmodule

// File: rtl/mvu_cmd_sequencer.sv
// rtl/mvu_cmd_sequencer.sv - command sequencer driving NMVU MVU control and weight-write ports
//
// Purpose: consumes a valid/ready command stream and turns it into registered
// one-cycle pulses on the per-channel MVU control and weight-write ports,
// with sticky done tracking, a per-job watchdog and sticky error flags.
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                 : command handshake
//   cmd_op/cmd_ch/cmd_addr/cmd_word     : command fields
//   tmo_limit                           : WAIT timeout in cycles, 0 = no timeout
//   err_clr                             : clear ERROR state and sticky flags
//   mvu_done                            : per-channel done pulses from the MVUs
//   mvu_start/mvu_ic_clr/mvu_shacc_clr  : per-channel control pulses
//   wrw_en/wrw_addr/wrw_word            : weight write port
//   busy                                : waiting on a channel's done
//   err_timeout/err_illegal/err_ch      : sticky error flags, last timed-out channel
module mvu_cmd_sequencer
    import mvu_seq_pkg::*;
#(
    parameter int NMVU   = 8,
    parameter int ADDR_W = 15,
    parameter int WORD_W = 64,
    parameter int TMO_W  = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [$clog2(NMVU)-1:0] cmd_ch,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [WORD_W-1:0]       cmd_word,
    input  logic [TMO_W-1:0]        tmo_limit,
    input  logic                    err_clr,
    input  logic [NMVU-1:0]         mvu_done,
    output logic [NMVU-1:0]         mvu_start,
    output logic [NMVU-1:0]         mvu_ic_clr,
    output logic [NMVU-1:0]         mvu_shacc_clr,
    output logic [NMVU-1:0]         wrw_en,
    output logic [ADDR_W-1:0]       wrw_addr,
    output logic [WORD_W-1:0]       wrw_word,
    output logic                    busy,
    output logic                    err_timeout,
    output logic                    err_illegal,
    output logic [$clog2(NMVU)-1:0] err_ch
);

    localparam int CH_W = $clog2(NMVU);

    seq_state_t        state_q, state_d;
    logic [CH_W-1:0]   wait_ch_q, wait_ch_d;
    logic [NMVU-1:0]   done_seen_q, done_seen_d;

    logic [NMVU-1:0]   start_d, clr_d, wrw_en_d, ch_onehot, start_mask;
    logic [ADDR_W-1:0] wrw_addr_d;
    logic [WORD_W-1:0] wrw_word_d;
    logic [CH_W-1:0]   err_ch_d;
    logic              err_timeout_d, err_illegal_d;
    logic              tmo_set, ill_set;
    logic              accept, legal, cmd_done, wait_done;
    logic              wd_clear, wd_run, wd_expired;
    seq_op_t           op;

    assign cmd_ready = (state_q != ST_WAIT);
    assign busy      = (state_q == ST_WAIT);

    always_comb begin
        state_d     = state_q;
        wait_ch_d   = wait_ch_q;
        start_d     = '0;
        clr_d       = '0;
        wrw_en_d    = '0;
        start_mask  = '0;
        wrw_addr_d  = wrw_addr;
        wrw_word_d  = wrw_word;
        err_ch_d    = err_ch;
        tmo_set     = 1'b0;
        ch_onehot   = '0;
        ch_onehot[cmd_ch] = 1'b1;

        op        = seq_op_t'(cmd_op);
        accept    = cmd_valid && cmd_ready;
        legal     = seq_op_legal(op) && (int'(cmd_ch) < NMVU);
        // A done pulse arriving in the same cycle counts as already seen.
        cmd_done  = done_seen_q[cmd_ch] | mvu_done[cmd_ch];
        wait_done = done_seen_q[wait_ch_q] | mvu_done[wait_ch_q];

        case (state_q)
            ST_IDLE: begin
                if (accept && legal) begin
                    case (op)
                        OP_WRW: begin
                            wrw_en_d   = ch_onehot;
                            wrw_addr_d = cmd_addr;
                            wrw_word_d = cmd_word;
                        end
                        OP_CLR: begin
                            clr_d = ch_onehot;
                        end
                        OP_START: begin
                            start_d    = ch_onehot;
                            start_mask = ch_onehot;
                        end
                        OP_WAIT: begin
                            if (!cmd_done) begin
                                state_d   = ST_WAIT;
                                wait_ch_d = cmd_ch;
                            end
                        end
                        OP_START_WAIT: begin
                            // The start clears done_seen, so a stale done
                            // can never satisfy this wait.
                            start_d    = ch_onehot;
                            start_mask = ch_onehot;
                            state_d    = ST_WAIT;
                            wait_ch_d  = cmd_ch;
                        end
                        OP_BWRW: begin
                            wrw_en_d   = '1;
                            wrw_addr_d = cmd_addr;
                            wrw_word_d = cmd_word;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_d = ST_IDLE;
                end else if (wd_expired) begin
                    state_d  = ST_ERROR;
                    tmo_set  = 1'b1;
                    err_ch_d = wait_ch_q;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ill_set       = accept && !legal;
        // A new error event in the same cycle as err_clr stays visible.
        err_timeout_d = (err_timeout & ~err_clr) | tmo_set;
        err_illegal_d = (err_illegal & ~err_clr) | ill_set;
        // Start clear wins over a coincident done pulse on the same channel.
        done_seen_d   = (done_seen_q | mvu_done) & ~start_mask;

        wd_run   = (state_q == ST_WAIT);
        wd_clear = (state_q != ST_WAIT) || (state_d != ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wait_ch_q     <= '0;
            done_seen_q   <= '0;
            mvu_start     <= '0;
            mvu_ic_clr    <= '0;
            mvu_shacc_clr <= '0;
            wrw_en        <= '0;
            wrw_addr      <= '0;
            wrw_word      <= '0;
            err_timeout   <= 1'b0;
            err_illegal   <= 1'b0;
            err_ch        <= '0;
        end else begin
            state_q       <= state_d;
            wait_ch_q     <= wait_ch_d;
            done_seen_q   <= done_seen_d;
            mvu_start     <= start_d;
            mvu_ic_clr    <= clr_d;
            mvu_shacc_clr <= clr_d;
            wrw_en        <= wrw_en_d;
            wrw_addr      <= wrw_addr_d;
            wrw_word      <= wrw_word_d;
            err_timeout   <= err_timeout_d;
            err_illegal   <= err_illegal_d;
            err_ch        <= err_ch_d;
        end
    end

    mvu_seq_watchdog #(
        .TMO_W (TMO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .run     (wd_run),
        .limit   (tmo_limit),
        .expired (wd_expired)
    );

endmodule

// File: tb/tb_mvu_cmd_sequencer.sv
// tb/tb_mvu_cmd_sequencer.sv - scoreboard bench for mvu_cmd_sequencer
module tb_mvu_cmd_sequencer;
    import mvu_seq_pkg::*;

    localparam int N  = 8;
    localparam int AW = 15;
    localparam int WW = 64;
    localparam int TW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    seq_cmd_t      cmd = '0;
    logic [TW-1:0] tmo_limit = '0;
    logic          err_clr = 1'b0;
    logic [N-1:0]  mvu_done = '0;
    logic [N-1:0]  mvu_start, mvu_ic_clr, mvu_shacc_clr, wrw_en;
    logic [AW-1:0] wrw_addr;
    logic [WW-1:0] wrw_word;
    logic          busy, err_timeout, err_illegal;
    logic [2:0]    err_ch;

    mvu_cmd_sequencer #(.NMVU(N), .ADDR_W(AW), .WORD_W(WW), .TMO_W(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd.op),
        .cmd_ch        (cmd.ch),
        .cmd_addr      (cmd.addr),
        .cmd_word      (cmd.word),
        .tmo_limit     (tmo_limit),
        .err_clr       (err_clr),
        .mvu_done      (mvu_done),
        .mvu_start     (mvu_start),
        .mvu_ic_clr    (mvu_ic_clr),
        .mvu_shacc_clr (mvu_shacc_clr),
        .wrw_en        (wrw_en),
        .wrw_addr      (wrw_addr),
        .wrw_word      (wrw_word),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .err_illegal   (err_illegal),
        .err_ch        (err_ch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  start;
        logic [N-1:0]  ic;
        logic [N-1:0]  sh;
        logic [N-1:0]  wen;
        logic [AW-1:0] addr;
        logic [WW-1:0] word;
        logic          busy;
        logic          ready;
        logic          tmo;
        logic          ill;
        logic [2:0]    ech;
    } obs_t;

    obs_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: mode 0 = idle, 1 = waiting, 2 = error.
    int            m_mode = 0;
    int            m_wch  = 0;
    int            m_cnt  = 0;
    logic [N-1:0]  m_done = '0;
    logic          m_tmo  = 1'b0;
    logic          m_ill  = 1'b0;
    logic [2:0]    m_ech  = '0;
    logic [AW-1:0] m_addr = '0;
    logic [WW-1:0] m_word = '0;

    // Called at a falling edge with inputs stable: predicts what the DUT
    // shows after the next rising edge, queues it, advances one cycle.
    task automatic step();
        obs_t         e;
        int           op, ch, lim;
        bit           acc, legal, tmo_set, ill_set;
        logic [N-1:0] clrm;
        e = '0;
        if (!rst_n) begin
            m_mode = 0; m_wch = 0; m_cnt = 0; m_done = '0;
            m_tmo = 0; m_ill = 0; m_ech = '0; m_addr = '0; m_word = '0;
        end else begin
            op      = int'(cmd.op);
            ch      = int'(cmd.ch);
            lim     = int'(tmo_limit);
            acc     = cmd_valid && (m_mode != 1);
            legal   = (op != 7) && (ch < N);
            clrm    = '0;
            tmo_set = 0;
            case (m_mode)
                0: if (acc && legal) begin
                    case (op)
                        1: begin e.wen[ch] = 1'b1; m_addr = cmd.addr; m_word = cmd.word; end
                        2: begin e.ic[ch] = 1'b1; e.sh[ch] = 1'b1; end
                        3: begin e.start[ch] = 1'b1; clrm[ch] = 1'b1; end
                        4: if (!(m_done[ch] || mvu_done[ch])) begin
                               m_mode = 1; m_wch = ch; m_cnt = 0;
                           end
                        5: begin
                               e.start[ch] = 1'b1; clrm[ch] = 1'b1;
                               m_mode = 1; m_wch = ch; m_cnt = 0;
                           end
                        6: begin e.wen = '1; m_addr = cmd.addr; m_word = cmd.word; end
                        default: ;
                    endcase
                end
                1: begin
                    if (m_done[m_wch] || mvu_done[m_wch]) m_mode = 0;
                    else if (lim != 0 && m_cnt >= lim - 1) begin
                        m_mode = 2; tmo_set = 1; m_ech = 3'(m_wch);
                    end else if (m_cnt < (1 << TW) - 1) m_cnt++;
                end
                2: if (err_clr) m_mode = 0;
                default: ;
            endcase
            ill_set = acc && !legal;
            m_tmo   = (m_tmo && !err_clr) || tmo_set;
            m_ill   = (m_ill && !err_clr) || ill_set;
            m_done  = (m_done | mvu_done) & ~clrm;
        end
        e.addr  = m_addr;
        e.word  = m_word;
        e.busy  = (m_mode == 1);
        e.ready = (m_mode != 1);
        e.tmo   = m_tmo;
        e.ill   = m_ill;
        e.ech   = m_ech;
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic send(input int op, input int ch, input int addr, input logic [WW-1:0] w);
        int guard;
        bit acc;
        logic [2:0]    op3;
        logic [2:0]    ch3;
        logic [AW-1:0] a;
        op3 = op[2:0];
        ch3 = ch[2:0];
        a   = addr[AW-1:0];
        cmd.op = seq_op_t'(op3); cmd.ch = ch3; cmd.addr = a; cmd.word = w;
        cmd_valid = 1'b1;
        guard = 0;
        do begin
            acc = (m_mode != 1);
            step();
            guard++;
        end while (!acc && guard < 5000);
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL send_accept op=%0d ch=%0d not accepted within %0d cycles", op, ch, guard);
        end
        cmd_valid = 1'b0;
    endtask

    // Monitor: compares the DUT outputs against the queued prediction
    // shortly after every rising edge.
    initial begin
        obs_t e, got;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                got = {mvu_start, mvu_ic_clr, mvu_shacc_clr, wrw_en, wrw_addr, wrw_word,
                       busy, cmd_ready, err_timeout, err_illegal, err_ch};
                n_tests++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, e);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single-channel weight write.
        send(1, 2, 'h10, 64'hDEAD);
        repeat (2) step();

        // Broadcast write followed immediately by a clear.
        send(6, 0, 'h7FFF, {$urandom, $urandom});
        send(2, 0, 0, 64'h0);
        repeat (2) step();

        // START_WAIT on ch 5; a NOP sits queued until the done arrives.
        send(5, 5, 0, 64'h0);
        cmd.op = OP_NOP; cmd_valid = 1'b1;
        repeat (11) step();
        mvu_done = 8'h20;
        step();
        mvu_done = '0;
        step();
        cmd_valid = 1'b0;
        step();

        // Watchdog timeout, dropped command in ERROR, then recovery.
        tmo_limit = 100;
        send(5, 3, 0, 64'h0);
        repeat (105) step();
        send(1, 1, 'h22, 64'h1234);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();

        // Done seen before WAIT completes at once; START with a
        // coincident done must still leave WAIT pending.
        mvu_done = 8'h02;
        step();
        mvu_done = '0;
        send(4, 1, 0, 64'h0);
        step();
        mvu_done = 8'h02;
        send(3, 1, 0, 64'h0);
        mvu_done = '0;
        send(4, 1, 0, 64'h0);
        repeat (5) step();
        mvu_done = 8'h02;
        step();
        mvu_done = '0;
        step();

        // Illegal opcode, then clear the flag.
        send(7, 4, 0, 64'h0);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;

        // Asynchronous reset in the middle of a WAIT.
        send(5, 0, 0, 64'h0);
        repeat (3) step();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [2:0] rop, rch;
            rop = 3'($urandom_range(0, 7));
            rch = 3'($urandom_range(0, 7));
            if (i % 200 == 0)
                tmo_limit = ($urandom_range(0, 3) == 0) ? '0 : TW'($urandom_range(1, 40));
            cmd.op    = seq_op_t'(rop);
            cmd.ch    = rch;
            cmd.addr  = AW'($urandom);
            cmd.word  = {$urandom, $urandom};
            cmd_valid = ($urandom_range(0, 9) < 7);
            mvu_done  = ($urandom_range(0, 99) < 15) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            err_clr   = ($urandom_range(0, 99) < 3);
            step();
        end
        cmd_valid = 1'b0; mvu_done = '0; err_clr = 1'b0;
        repeat (3) step();

        @(posedge clk);
        #3;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d entries left exp=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
